// File: rtl/wordcopy_pkg.sv
// Shared types and constants for the wordcopy memory-to-memory copy engine.
// Holds the FSM state encoding, the slave register offsets and address arithmetic.
package wordcopy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  localparam logic [3:0] REG_START = 4'd0;
  localparam logic [3:0] REG_DEST  = 4'd1;
  localparam logic [3:0] REG_SRC   = 4'd2;
  localparam logic [3:0] REG_NUM   = 4'd3;

  // Byte address of word `idx` past `base`; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/wordcopy_if.sv
// Bus bundle for wordcopy: the configuration slave port plus the memory master port.
// The slave modport is the engine's own view; the master modport is the system side.
interface wordcopy_if;

  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        slave_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest;

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata,
    input  master_readdata, master_readdatavalid, master_waitrequest,
    output slave_readdata, slave_waitrequest,
    output master_address, master_read, master_write, master_writedata
  );

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata,
    output master_readdata, master_readdatavalid, master_waitrequest,
    input  slave_readdata, slave_waitrequest,
    input  master_address, master_read, master_write, master_writedata
  );

endinterface

// File: rtl/wordcopy.sv
// Simple DMA: copies num_words 32-bit words from src to dest, one read/write pair at a time.
// Registers are writable only in IDLE; the slave port stalls while a copy runs.
module wordcopy
  import wordcopy_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  wordcopy_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] dest_q, dest_d;
  logic [31:0] src_q, src_d;
  logic [31:0] num_q, num_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] data_q, data_d;

  // State and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= 32'd0;
      src_q   <= 32'd0;
      num_q   <= 32'd0;
      idx_q   <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next-state: register writes in IDLE, copy sequencing otherwise
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    src_d   = src_q;
    num_d   = num_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.slave_write) begin
          case (bus.slave_address)
            REG_START: begin
              idx_d = 32'd0;
              // A zero-length copy is a no-op
              if (num_q != 32'd0) state_d = ST_READ;
              else                state_d = ST_IDLE;
            end
            REG_DEST: dest_d  = bus.slave_writedata;
            REG_SRC:  src_d   = bus.slave_writedata;
            REG_NUM:  num_d   = bus.slave_writedata;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!bus.master_waitrequest) state_d = ST_WAIT;
        else                         state_d = ST_READ;
      end
      ST_WAIT: begin
        if (bus.master_readdatavalid) begin
          data_d  = bus.master_readdata;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_LOAD: state_d = ST_WRITE;
      ST_WRITE: begin
        if (!bus.master_waitrequest) begin
          if (idx_q + 32'd1 == num_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 32'd1;
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Master outputs decoded from registered state and index
  always_comb begin
    bus.master_read    = 1'b0;
    bus.master_write   = 1'b0;
    bus.master_address = 32'd0;
    case (state_q)
      ST_READ: begin
        bus.master_read    = 1'b1;
        bus.master_address = word_addr(src_q, idx_q);
      end
      ST_WRITE: begin
        bus.master_write   = 1'b1;
        bus.master_address = word_addr(dest_q, idx_q);
      end
      default: begin
        bus.master_read    = 1'b0;
        bus.master_write   = 1'b0;
        bus.master_address = 32'd0;
      end
    endcase
    bus.master_writedata  = data_q;
    bus.slave_waitrequest = (state_q != ST_IDLE);
  end

  // Slave read mux; the start offset and unmapped offsets read as zero
  always_comb begin
    bus.slave_readdata = 32'd0;
    if (bus.slave_read) begin
      case (bus.slave_address)
        REG_DEST: bus.slave_readdata = dest_q;
        REG_SRC:  bus.slave_readdata = src_q;
        REG_NUM:  bus.slave_readdata = num_q;
        default:  bus.slave_readdata = 32'd0;
      endcase
    end else begin
      bus.slave_readdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_wordcopy.sv
// Self-checking bench for wordcopy: directed protocol steps, then randomized copies
// against a word-level memory model and expected transaction lists.
module tb_wordcopy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wordcopy_if bus ();

  wordcopy dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rlog [$];
  logic [31:0] wlog_a [$];
  logic [31:0] wlog_d [$];
  bit          rand_mode = 1'b0;
  logic        forced_wr = 1'b0;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [31:0] paddr = 32'd0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else               return ~a;
  endfunction

  // Memory responder: samples accepted requests at the edge, drives responses 2 units later
  always @(posedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (bus.master_read && !bus.master_waitrequest) begin
        rlog.push_back(bus.master_address);
        pend  = 1'b1;
        paddr = bus.master_address;
        lat   = rand_mode ? int'($urandom_range(0, 2)) : 0;
      end
      if (bus.master_write && !bus.master_waitrequest) begin
        mem[bus.master_address] = bus.master_writedata;
        wlog_a.push_back(bus.master_address);
        wlog_d.push_back(bus.master_writedata);
      end
    end
    #2;
    bus.master_waitrequest = rand_mode ? ($urandom_range(0, 2) == 0) : forced_wr;
    if (pend && lat == 0) begin
      bus.master_readdatavalid = 1'b1;
      bus.master_readdata      = mem_rd(paddr);
      pend                     = 1'b0;
    end else begin
      bus.master_readdatavalid = 1'b0;
      bus.master_readdata      = $urandom;
      if (pend) lat = lat - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    bus.slave_address   = a;
    bus.slave_writedata = d;
    bus.slave_write     = 1'b1;
    tick();
    bus.slave_write     = 1'b0;
  endtask

  task automatic reg_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus.slave_address = a;
    bus.slave_read    = 1'b1;
    tick();
    check(tag, bus.slave_readdata, exp);
    bus.slave_read    = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (bus.slave_waitrequest && k < max_cyc) begin
      tick();
      k++;
    end
    check("idle_timeout", {31'd0, bus.slave_waitrequest}, 32'd0);
  endtask

  task automatic clear_logs();
    rlog.delete();
    wlog_a.delete();
    wlog_d.delete();
  endtask

  initial begin
    logic [31:0] src, dst, n;
    logic [31:0] exp_q [$];
    int k;

    bus.slave_address        = 4'd0;
    bus.slave_read           = 1'b0;
    bus.slave_write          = 1'b0;
    bus.slave_writedata      = 32'd0;
    bus.master_readdata      = 32'd0;
    bus.master_readdatavalid = 1'b0;
    bus.master_waitrequest   = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_wait", {31'd0, bus.slave_waitrequest}, 32'd0);
    check("rst_rd",   {31'd0, bus.master_read}, 32'd0);
    check("rst_wr",   {31'd0, bus.master_write}, 32'd0);
    check("rst_addr", bus.master_address, 32'd0);
    check("rst_wdat", bus.master_writedata, 32'd0);
    rst = 1'b0;
    tick();
    reg_read_chk("rst_dest", 4'd1, 32'd0);

    // Configuration and readback
    mem[32'd256] = 32'd1;
    mem[32'd260] = 32'd2;
    mem[32'd264] = 32'd3;
    reg_write(4'd1, 32'd0);
    reg_write(4'd2, 32'd256);
    reg_write(4'd3, 32'd3);
    reg_read_chk("cfg_dest", 4'd1, 32'd0);
    reg_read_chk("cfg_src",  4'd2, 32'd256);
    reg_read_chk("cfg_num",  4'd3, 32'd3);
    reg_read_chk("cfg_a0",   4'd0, 32'd0);
    reg_read_chk("cfg_a9",   4'd9, 32'd0);
    check("cfg_wait", {31'd0, bus.slave_waitrequest}, 32'd0);
    check("cfg_rdwr", {30'd0, bus.master_read, bus.master_write}, 32'd0);

    // Start with a stalled read
    clear_logs();
    forced_wr = 1'b1;
    reg_write(4'd0, 32'hFFFF_FFFF);
    check("st_rd",   {31'd0, bus.master_read}, 32'd1);
    check("st_addr", bus.master_address, 32'd256);
    check("st_wait", {31'd0, bus.slave_waitrequest}, 32'd1);
    tick();
    check("st_hold", {31'd0, bus.master_read}, 32'd1);
    forced_wr = 1'b0;
    tick();
    check("st_rel",  {30'd0, bus.master_read, bus.master_write}, 32'd0);
    tick();
    check("load_idle", {30'd0, bus.master_read, bus.master_write}, 32'd0);
    forced_wr = 1'b1;
    tick();
    check("wr_req",  {31'd0, bus.master_write}, 32'd1);
    check("wr_addr", bus.master_address, 32'd0);
    check("wr_data", bus.master_writedata, 32'd1);
    tick();
    check("wr_hold", {31'd0, bus.master_write}, 32'd1);
    forced_wr = 1'b0;
    wait_idle(200);
    check("full_m0", mem_rd(32'd0), 32'd1);
    check("full_m4", mem_rd(32'd4), 32'd2);
    check("full_m8", mem_rd(32'd8), 32'd3);
    check("full_nr", rlog.size(), 32'd3);
    check("full_nw", wlog_a.size(), 32'd3);
    for (int i = 0; i < 3 && i < rlog.size() && i < wlog_a.size(); i++) begin
      check("full_ra", rlog[i], 32'd256 + 32'(4 * i));
      check("full_wa", wlog_a[i], 32'(4 * i));
    end

    // Back-to-back restart with slave_write held at the start offset
    clear_logs();
    bus.slave_address = 4'd0;
    bus.slave_write   = 1'b1;
    tick();
    k = 0;
    while (wlog_a.size() < 3 && k < 200) begin
      tick();
      k++;
    end
    check("bb_first3", wlog_a.size(), 32'd3);
    check("bb_idle",   {31'd0, bus.slave_waitrequest}, 32'd0);
    check("bb_idle_rd", {31'd0, bus.master_read}, 32'd0);
    tick();
    bus.slave_write = 1'b0;
    check("bb_rd",   {31'd0, bus.master_read}, 32'd1);
    check("bb_addr", bus.master_address, 32'd256);
    check("bb_wait", {31'd0, bus.slave_waitrequest}, 32'd1);
    wait_idle(200);
    check("bb_nw", wlog_a.size(), 32'd6);
    check("bb_nr", rlog.size(), 32'd6);

    // Zero-length copy is a no-op
    reg_write(4'd3, 32'd0);
    clear_logs();
    reg_write(4'd0, 32'd0);
    check("z_wait", {31'd0, bus.slave_waitrequest}, 32'd0);
    check("z_rd",   {31'd0, bus.master_read}, 32'd0);
    repeat (3) tick();
    check("z_nbus", rlog.size() + wlog_a.size(), 32'd0);

    // Asynchronous reset while in WRITE
    reg_write(4'd3, 32'd2);
    reg_write(4'd0, 32'd0);
    k = 0;
    while (!bus.master_write && k < 50) begin
      tick();
      k++;
    end
    check("r_inwr", {31'd0, bus.master_write}, 32'd1);
    forced_wr = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("r_wr",   {31'd0, bus.master_write}, 32'd0);
    check("r_rd",   {31'd0, bus.master_read}, 32'd0);
    check("r_addr", bus.master_address, 32'd0);
    check("r_wdat", bus.master_writedata, 32'd0);
    check("r_wait", {31'd0, bus.slave_waitrequest}, 32'd0);
    tick();
    rst = 1'b0;
    forced_wr = 1'b0;
    tick();
    reg_read_chk("r_src", 4'd2, 32'd0);
    reg_read_chk("r_num", 4'd3, 32'd0);

    // Randomized copies with random stalls and read latency
    rand_mode = 1'b1;
    for (int it = 0; it < 8; it++) begin
      src = (it == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      dst = src + 32'h0001_0000;
      n   = $urandom_range(1, 6);
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back($urandom);
        mem[src + 32'(4 * i)] = exp_q[i];
      end
      reg_write(4'd1, dst);
      reg_write(4'd2, src);
      reg_write(4'd3, n);
      clear_logs();
      reg_write(4'd0, 32'd0);
      wait_idle(600);
      check("rnd_nr", rlog.size(), n);
      check("rnd_nw", wlog_a.size(), n);
      for (int i = 0; i < int'(n) && i < rlog.size() && i < wlog_a.size(); i++) begin
        check("rnd_ra", rlog[i], src + 32'(4 * i));
        check("rnd_wa", wlog_a[i], dst + 32'(4 * i));
        check("rnd_wd", wlog_d[i], exp_q[i]);
        check("rnd_mem", mem_rd(dst + 32'(4 * i)), exp_q[i]);
      end
    end
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
